// File: rtl/register_write_arbiter.sv
// register_write_arbiter
//
// Shares the single write port of the 32x64 register bank between two
// writeback requesters (0 = ALU result, 1 = memory load result). The winner
// of a round-robin arbitration is registered into the bank write inputs. Writes
// to the zero register are accepted but never enabled. The registered write is
// forwarded combinationally to both read ports.
//
// Handshake (both requesters): a write transfers on a rising clock edge where
// validN && readyN. readyN is combinational from valid0, valid1, hold and
// last_grant only (never from addressN/dataN). A requester keeps validN,
// addressN and dataN stable until it is accepted. At most one ready is high.
//
// Ports:
//   clock, reset_n                  clock, asynchronous active-low reset
//   hold                            stall: no grants while high
//   valid0/address0/data0/ready0    requester 0 write channel
//   valid1/address1/data1/ready1    requester 1 write channel
//   write_enable/address/data       registered bank write port
//   read_address1/2                 operand read indices
//   forward_hit1/2, forward_data1/2 forwarding of the registered write
//   last_grant                      requester granted most recently
module register_write_arbiter #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 5,
    parameter int ZERO_REGISTER = 31
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  hold,
    input  logic                  valid0,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  ready0,
    input  logic                  valid1,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ready1,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_address1,
    input  logic [ADDR_WIDTH-1:0] read_address2,
    output logic                  forward_hit1,
    output logic                  forward_hit2,
    output logic [DATA_WIDTH-1:0] forward_data1,
    output logic [DATA_WIDTH-1:0] forward_data2,
    output logic                  last_grant
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REGISTER);

    logic                  grant0;
    logic                  grant1;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  write_enable_q,  write_enable_d;
    logic [ADDR_WIDTH-1:0] write_address_q, write_address_d;
    logic [DATA_WIDTH-1:0] write_data_q,    write_data_d;
    logic                  last_grant_q,    last_grant_d;

    // Round-robin: when both requesters are valid, the one that did not win
    // last time is granted. A lone requester is granted unconditionally.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!hold) begin
            if (valid0 && valid1) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    assign transfer    = grant0 || grant1;
    assign sel_address = grant1 ? address1 : address0;
    assign sel_data    = grant1 ? data1 : data0;

    always_comb begin
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        last_grant_d    = last_grant_q;
        if (transfer) begin
            // A zero-register write is consumed (ready, last_grant update)
            // but never reaches the bank.
            write_enable_d  = (sel_address != ZERO_ADDR);
            write_address_d = sel_address;
            write_data_d    = sel_data;
            last_grant_d    = grant1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            last_grant_q    <= 1'b1;
        end else begin
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            last_grant_q    <= last_grant_d;
        end
    end

    assign ready0        = grant0;
    assign ready1        = grant1;
    assign write_enable  = write_enable_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign last_grant    = last_grant_q;

    // The registered write is what the bank commits next edge, so operand
    // reads of the same index must take it from here.
    assign forward_hit1  = write_enable_q && (write_address_q == read_address1);
    assign forward_hit2  = write_enable_q && (write_address_q == read_address2);
    assign forward_data1 = forward_hit1 ? write_data_q : '0;
    assign forward_data2 = forward_hit2 ? write_data_q : '0;

endmodule

// File: tb/tb_register_write_arbiter.sv
module tb_register_write_arbiter;

    localparam int EW = 16 + 1 + 1 + 5 + 64;

    logic        clock;
    logic        reset_n;
    logic        hold;
    logic        valid0;
    logic [4:0]  address0;
    logic [63:0] data0;
    logic        ready0;
    logic        valid1;
    logic [4:0]  address1;
    logic [63:0] data1;
    logic        ready1;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [63:0] write_data;
    logic [4:0]  read_address1;
    logic [4:0]  read_address2;
    logic        forward_hit1;
    logic        forward_hit2;
    logic [63:0] forward_data1;
    logic [63:0] forward_data2;
    logic        last_grant;

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;

    // entry = {edge tag[15:0], last_grant, write_enable, write_address, write_data}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] ent;

    logic [63:0] bank [32];
    bit          bank_ready = 1'b0;

    register_write_arbiter dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .hold          (hold),
        .valid0        (valid0),
        .address0      (address0),
        .data0         (data0),
        .ready0        (ready0),
        .valid1        (valid1),
        .address1      (address1),
        .data1         (data1),
        .ready1        (ready1),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_address1 (read_address1),
        .read_address2 (read_address2),
        .forward_hit1  (forward_hit1),
        .forward_hit2  (forward_hit2),
        .forward_data1 (forward_data1),
        .forward_data2 (forward_data2),
        .last_grant    (last_grant)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Register bank model: commits the registered write one edge later.
    always @(posedge clock) begin
        if (!bank_ready) begin
            for (int i = 0; i < 32; i++) bank[i] <= 64'h1000 + 64'(i);
            bank_ready <= 1'b1;
        end else if (write_enable) begin
            bank[write_address] <= write_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of stimulus, checks the combinational readies and
    // queues the registered output expected after the coming edge.
    task automatic drive(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                         input logic h, input logic er0, input logic er1,
                         input logic ewe, input logic [4:0] ea, input logic [63:0] ed,
                         input logic elg);
        logic [15:0] tag;
        @(posedge clock);
        #1;
        valid0 = v0; address0 = a0; data0 = d0;
        valid1 = v1; address1 = a1; data1 = d1;
        hold = h;
        #2;
        check("ready0", ready0, er0);
        check("ready1", ready1, er1);
        tag = 16'(edge_cnt + 1);
        exp_q.push_back({tag, elg, ewe, ea, ed});
    endtask

    task automatic fwd(input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic eh1, input logic [63:0] ed1,
                       input logic eh2, input logic [63:0] ed2);
        read_address1 = ra1;
        read_address2 = ra2;
        #1;
        check("forward_hit1", forward_hit1, eh1);
        check("forward_data1", forward_data1, ed1);
        check("forward_hit2", forward_hit2, eh2);
        check("forward_data2", forward_data2, ed2);
    endtask

    // scoreboard monitor: compares registered outputs once their edge has passed
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            ent = exp_q[0];
            if (ent[86:71] == 16'(edge_cnt)) begin
                void'(exp_q.pop_front());
                check("last_grant", last_grant, ent[70]);
                check("write_enable", write_enable, ent[69]);
                check("write_address", write_address, ent[68:64]);
                check("write_data", write_data, ent[63:0]);
            end else if (ent[86:71] < 16'(edge_cnt)) begin
                void'(exp_q.pop_front());
                vectors++;
                miscompares++;
                $display("FAIL sb_missed: tag %0d edge %0d", ent[86:71], edge_cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        hold = 1'b0;
        valid0 = 1'b0; address0 = '0; data0 = '0;
        valid1 = 1'b0; address1 = '0; data1 = '0;
        read_address1 = '0; read_address2 = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_write_enable", write_enable, 0);
        check("rst_write_address", write_address, 0);
        check("rst_write_data", write_data, 0);
        check("rst_last_grant", last_grant, 1);
        check("rst_forward_hit1", forward_hit1, 0);
        check("rst_forward_hit2", forward_hit2, 0);
        reset_n = 1'b1;

        // single requester 0
        drive(1, 3, 64'hAAAA, 0, 0, 0, 0, 1, 0, 1, 3, 64'hAAAA, 0);
        // single requester 1; previous write forwarded
        drive(0, 0, 0, 1, 5, 64'h55, 0, 0, 1, 1, 5, 64'h55, 1);
        fwd(3, 5, 1, 64'hAAAA, 0, 0);
        // contested every cycle: grants 0,1,0,1
        drive(1, 1, 64'h11, 1, 2, 64'h22, 0, 1, 0, 1, 1, 64'h11, 0);
        drive(1, 1, 64'h11, 1, 2, 64'h22, 0, 0, 1, 1, 2, 64'h22, 1);
        drive(1, 1, 64'h11, 1, 2, 64'h22, 0, 1, 0, 1, 1, 64'h11, 0);
        drive(1, 1, 64'h11, 1, 2, 64'h22, 0, 0, 1, 1, 2, 64'h22, 1);
        // zero register: accepted, never enabled
        drive(0, 0, 0, 1, 31, 64'h5, 0, 0, 1, 0, 31, 64'h5, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 64'h5, 1);
        fwd(31, 31, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 64'h5, 1);
        // hold: registered write still presented, no grants
        drive(1, 9, 64'h99, 0, 0, 0, 0, 1, 0, 1, 9, 64'h99, 0);
        drive(1, 4, 64'h44, 1, 6, 64'h66, 1, 0, 0, 0, 9, 64'h99, 0);
        fwd(9, 4, 1, 64'h99, 0, 0);
        drive(1, 4, 64'h44, 1, 6, 64'h66, 1, 0, 0, 0, 9, 64'h99, 0);
        fwd(9, 9, 0, 0, 0, 0);
        drive(1, 4, 64'h44, 1, 6, 64'h66, 1, 0, 0, 0, 9, 64'h99, 0);
        // release: opposite of last_grant (0) wins
        drive(1, 4, 64'h44, 1, 6, 64'h66, 0, 0, 1, 1, 6, 64'h66, 1);
        drive(1, 4, 64'h44, 0, 0, 0, 0, 1, 0, 1, 4, 64'h44, 0);
        // forwarding
        drive(1, 7, 64'h1234, 0, 0, 0, 0, 1, 0, 1, 7, 64'h1234, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 64'h1234, 0);
        fwd(7, 8, 1, 64'h1234, 0, 0);
        // same address from both: requester 1 first, requester 0 wins bank
        drive(1, 10, 64'hA0, 1, 10, 64'hB0, 0, 0, 1, 1, 10, 64'hB0, 1);
        drive(1, 10, 64'hA0, 0, 0, 0, 0, 1, 0, 1, 10, 64'hA0, 0);
        fwd(10, 10, 1, 64'hB0, 1, 64'hB0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 64'hA0, 0);
        // reset mid-transfer drops the registered write
        drive(1, 7, 64'hDEAD, 0, 0, 0, 0, 1, 0, 1, 7, 64'hDEAD, 0);
        @(posedge clock);
        #6;
        reset_n = 1'b0;
        valid0 = 1'b0;
        read_address1 = 7;
        #1;
        check("midrst_write_enable", write_enable, 0);
        check("midrst_write_address", write_address, 0);
        check("midrst_write_data", write_data, 0);
        check("midrst_forward_hit1", forward_hit1, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_last_grant", last_grant, 1);

        check("bank1", bank[1], 64'h11);
        check("bank2", bank[2], 64'h22);
        check("bank3", bank[3], 64'hAAAA);
        check("bank4", bank[4], 64'h44);
        check("bank5", bank[5], 64'h55);
        check("bank6", bank[6], 64'h66);
        check("bank7", bank[7], 64'h1234);
        check("bank9", bank[9], 64'h99);
        check("bank10", bank[10], 64'hA0);
        check("bank31", bank[31], 64'h101F);
        check("sb_drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
- Shares the single write port of the 32x64 register bank between two writeback requesters: requester 0 (ALU result) and requester 1 (memory load result).
- Arbitrates round-robin and registers the winning write into the bank's write/address/data inputs.
- Suppresses writes to the zero register (X31/XZR).
- Forwards the in-flight write to both read ports so operand reads see it in the same cycle.

Parameters:
- DATA_WIDTH, 64, width of write/forward data.
- ADDR_WIDTH, 5, register index width (32 registers).
- ZERO_REGISTER, 31, index whose writes are discarded.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- hold  input  1  pipeline stall; no grants while high
- valid0  input  1  requester 0 has a write
- address0  input  ADDR_WIDTH  requester 0 destination register
- data0  input  DATA_WIDTH  requester 0 write data
- ready0  output  1  requester 0 accepted this cycle
- valid1, address1, data1, ready1: same as requester 0, for requester 1
- write_enable  output  1  to bank write
- write_address  output  ADDR_WIDTH  to bank destination index
- write_data  output  DATA_WIDTH  to bank write data
- read_address1, read_address2  input  ADDR_WIDTH  operand indices driven to the bank read ports
- forward_hit1, forward_hit2  output  1  pending write matches read index
- forward_data1, forward_data2  output  DATA_WIDTH  write_data when hit, else 0
- last_grant  output  1  requester granted most recently

Behaviour:
- Reset (asynchronous, reset_n low):
  - write_enable=0, write_address=0, write_data=0.
  - last_grant=1, so requester 0 has priority on the first contested cycle.
  - forward_hit*=0.
  - Reset asserted mid-transfer drops the registered write; the bank is not written.
- Handshake:
  - Transfer happens on a rising edge where validN && readyN.
  - readyN is combinational from valid0, valid1, hold and last_grant; it never depends on dataN.
  - A requester holds validN, addressN and dataN stable until accepted.
- Grant rules (hold=0):
  - Only valid0: ready0=1.
  - Only valid1: ready1=1.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant.
  - hold=1: ready0=ready1=0 regardless of valids. hold does not cancel an already registered write.
  - last_grant updates only on a transfer.
  - At most one ready is high per cycle.
- Output stage (one-cycle latency):
  - On a transfer, write_address and write_data register the granted address/data at the edge.
  - write_enable registers 1, unless the address equals ZERO_REGISTER, in which case it registers 0. The transfer is still accepted and last_grant still updates.
  - With no transfer, write_enable registers 0; write_address and write_data hold their values.
  - The bank commits the write at the following edge, so a value accepted at edge N is readable from the bank after edge N+1.
  - Back-to-back transfers are possible every cycle: the port sustains one write per cycle.
- Forwarding (combinational):
  - forward_hitK = write_enable && (write_address == read_addressK).
  - forward_dataK = write_data when forward_hitK, else 0.
  - Never hits on ZERO_REGISTER, because write_enable is never 1 for it.
- Same address from both requesters in one cycle: resolved purely by round-robin; the loser writes one cycle later. Its value therefore wins in the bank.
- No internal buffering beyond the output register; a requester stalls until granted.

Test Plan:
- Reset, then valid0=1, address0=3, data0=0xAAAA: ready0=1 in that cycle; next cycle write_enable=1, write_address=3, write_data=0xAAAA; last_grant=0.
- Both valid every cycle for 4 cycles (address0=1, address1=2): grants alternate 0,1,0,1; write_address sequence 1,2,1,2 with write_enable high each cycle.
- valid1=1, address1=31, data1=0x5: ready1=1; next cycle write_enable=0; a read of address 31 after two cycles returns the bank's prior contents unchanged; forward_hit never asserts.
- hold=1 for 3 cycles with both valid: ready0=ready1=0, write_enable=0 after the first cycle. Release hold: requester opposite last_grant is granted first.
- Accept address0=7, data0=0x1234; next cycle read_address1=7, read_address2=8: forward_hit1=1, forward_data1=0x1234, forward_hit2=0, forward_data2=0.
- Accept a write, then pull reset_n low before the next edge: write_enable drops to 0 immediately and register 7 is not updated. After release, last_grant=1.
